// File: rtl/bloom_query_pkg.sv
// Definitions shared by the Bloom filter query and insert paths, so that both
// sides compute bit-for-bit identical hashes.
package bloom_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HASH,
        PROBE,
        CHECK,
        RESP
    } bloom_q_state_e;

    localparam int BLOOM_HASH_MULT = 17;

    // Probe k starts from the all-ones value with k folded in, so each probe walks a distinct chain.
    function automatic int bloom_seed(input int k, input int h_bits);
        return ((1 << h_bits) - 1) ^ k;
    endfunction

endpackage

// File: rtl/bloom_query_if.sv
// Request, response and bit-array read signals of the Bloom query block.
// The slave modport is the query block's view; master is the surrounding system's view.
interface bloom_query_if #(
    parameter int D_SIZE    = 40,
    parameter int HASH_SIZE = 5
) ();

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [D_SIZE-1:0]    req_data_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic                 rsp_hit_o;
    logic                 bl_rd_req_o;
    logic [HASH_SIZE-1:0] bl_rd_addr_o;
    logic                 bl_rd_data_i;

    modport slave (
        input  req_valid_i,
        input  req_data_i,
        input  rsp_ready_i,
        input  bl_rd_data_i,
        output req_ready_o,
        output rsp_valid_o,
        output rsp_hit_o,
        output bl_rd_req_o,
        output bl_rd_addr_o
    );

    modport master (
        output req_valid_i,
        output req_data_i,
        output rsp_ready_i,
        output bl_rd_data_i,
        input  req_ready_o,
        input  rsp_valid_o,
        input  rsp_hit_o,
        input  bl_rd_req_o,
        input  bl_rd_addr_o
    );

endinterface

// File: rtl/bloom_hash_iter.sv
// Registered chunk-serial multiplicative hash: start loads the seed, and each
// step folds in one HASH_SIZE-bit chunk of the key. done flags the last chunk.
module bloom_hash_iter
    import bloom_pkg::*;
#(
    parameter int D_SIZE    = 40,
    parameter int HASH_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 step,
    input  logic [HASH_SIZE-1:0] seed,
    input  logic [D_SIZE-1:0]    key,
    output logic                 done,
    output logic [HASH_SIZE-1:0] h
);

    localparam int NUM_CHUNK = D_SIZE / HASH_SIZE;
    localparam int CW = (NUM_CHUNK > 1) ? $clog2(NUM_CHUNK) : 1;
    localparam logic [HASH_SIZE-1:0] MULT = HASH_SIZE'(BLOOM_HASH_MULT);

    logic [CW-1:0]        c_q;
    logic [HASH_SIZE-1:0] h_q;
    logic [HASH_SIZE-1:0] chunk;
    logic [HASH_SIZE-1:0] mixed;
    logic [HASH_SIZE-1:0] h_next;

    always_comb begin
        chunk = '0;
        for (int i = 0; i < NUM_CHUNK; i++) begin
            if (c_q == CW'(i)) begin
                chunk = key[i*HASH_SIZE +: HASH_SIZE];
            end
        end
    end

    // Truncating the product to HASH_SIZE bits is the mod 2**H of the hash.
    assign mixed  = h_q ^ chunk;
    assign h_next = mixed * MULT;
    assign done   = (c_q == CW'(NUM_CHUNK - 1));
    assign h      = h_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            c_q <= '0;
        end else if (start) begin
            h_q <= seed;
            c_q <= '0;
        end else if (step) begin
            h_q <= h_next;
            c_q <= done ? '0 : c_q + CW'(1);
        end
    end

endmodule

// File: rtl/bloom_query.sv
// Bloom filter membership query: hashes the key once per probe, reads one bit
// per probe from the bit array and reports hit/miss, stopping at the first zero bit.
module bloom_query
    import bloom_pkg::*;
#(
    parameter int D_SIZE    = 40,
    parameter int HASH_SIZE = 5,
    parameter int BL_SIZE   = 32,
    parameter int NUM_HASH  = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    bloom_query_if.slave bus,
    output logic         busy_o
);

    localparam int KW = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;

    if (D_SIZE % HASH_SIZE != 0) begin : g_bad_chunking
        $error("bloom_query: D_SIZE must be a multiple of HASH_SIZE");
    end
    if (BL_SIZE != (1 << HASH_SIZE)) begin : g_bad_depth
        $error("bloom_query: BL_SIZE must equal 2**HASH_SIZE");
    end
    if ((NUM_HASH < 1) || (NUM_HASH > BL_SIZE)) begin : g_bad_probes
        $error("bloom_query: NUM_HASH must be within 1..BL_SIZE");
    end

    bloom_q_state_e       state_q;
    bloom_q_state_e       state_d;
    logic [D_SIZE-1:0]    key_q;
    logic [KW-1:0]        k_q;
    logic                 hit_q;
    logic [HASH_SIZE-1:0] addr_q;
    logic [HASH_SIZE-1:0] seed_sel;
    logic [HASH_SIZE-1:0] h;
    logic                 start;
    logic                 step;
    logic                 done;
    logic                 accept;
    logic                 last_probe;
    int                   next_probe;

    assign accept     = (state_q == IDLE) && bus.req_valid_i;
    assign last_probe = (k_q == KW'(NUM_HASH - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        step       = 1'b0;
        next_probe = 0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    start   = 1'b1;
                    state_d = HASH;
                end
            end
            HASH: begin
                step = 1'b1;
                if (done) begin
                    state_d = PROBE;
                end
            end
            PROBE: begin
                state_d = CHECK;
            end
            CHECK: begin
                // A single zero bit proves absence, so the remaining probes are skipped.
                if (!bus.bl_rd_data_i || last_probe) begin
                    state_d = RESP;
                end else begin
                    start      = 1'b1;
                    next_probe = int'(k_q) + 1;
                    state_d    = HASH;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        seed_sel = HASH_SIZE'(bloom_seed(next_probe, HASH_SIZE));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q  <= '0;
            k_q    <= '0;
            hit_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            if (accept) begin
                key_q <= bus.req_data_i;
                k_q   <= '0;
            end
            if (state_q == PROBE) begin
                addr_q <= h;
            end
            if (state_q == CHECK) begin
                if (!bus.bl_rd_data_i) begin
                    hit_q <= 1'b0;
                end else if (last_probe) begin
                    hit_q <= 1'b1;
                end else begin
                    k_q <= k_q + KW'(1);
                end
            end
        end
    end

    bloom_hash_iter #(
        .D_SIZE    (D_SIZE),
        .HASH_SIZE (HASH_SIZE)
    ) u_hash (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .start (start),
        .step  (step),
        .seed  (seed_sel),
        .key   (key_q),
        .done  (done),
        .h     (h)
    );

    // The address register keeps the last probed address visible between strobes.
    assign bus.req_ready_o  = (state_q == IDLE);
    assign bus.rsp_valid_o  = (state_q == RESP);
    assign bus.rsp_hit_o    = hit_q;
    assign bus.bl_rd_req_o  = (state_q == PROBE);
    assign bus.bl_rd_addr_o = (state_q == PROBE) ? h : addr_q;
    assign busy_o           = (state_q != IDLE);

endmodule
